// File: rtl/bus_read_ctrl.sv
// Multiplexed address/data bus read sequencer: one edge-triggered read transaction
// through ADDR -> HOLD -> READ -> RECOV, with every pin driven from a register.
module bus_read_ctrl #(
    parameter int unsigned ADDR_CYC = 4,
    parameter int unsigned RD_CYC   = 6,
    parameter int unsigned GAP_CYC  = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] addr,
    input  logic [7:0] ad_in,
    output logic [7:0] ad_out,
    output logic       ad_oe,
    output logic       cs_n,
    output logic       ad_n,
    output logic       rd_n,
    output logic [7:0] data,
    output logic       done,
    output logic       busy
);

    // Counter reload values; a zero-length phase is stretched to one cycle.
    localparam logic [7:0] ADDR_LOAD = (ADDR_CYC == 0) ? 8'd0 : 8'(ADDR_CYC - 1);
    localparam logic [7:0] RD_LOAD   = (RD_CYC == 0)   ? 8'd0 : 8'(RD_CYC - 1);
    localparam logic [7:0] GAP_LOAD  = (GAP_CYC == 0)  ? 8'd0 : 8'(GAP_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_HOLD,
        S_READ,
        S_RECOV
    } state_t;

    state_t     r_state;
    state_t     w_state_next;
    logic [7:0] r_cnt;
    logic [7:0] w_cnt_next;
    logic       r_start_q;
    logic [7:0] r_addr_q;
    logic [7:0] r_data;
    logic       r_done;
    logic       r_busy;
    logic       r_cs_n;
    logic       r_ad_n;
    logic       r_rd_n;
    logic       r_ad_oe;
    logic       w_trigger;
    logic       w_capture;

    assign w_trigger = start && !r_start_q && (r_state == S_IDLE);
    assign w_capture = (r_state == S_READ) && (r_cnt == 8'd0);

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_trigger) begin
                    w_state_next = S_ADDR;
                    w_cnt_next   = ADDR_LOAD;
                end
            end
            S_ADDR: begin
                if (r_cnt == 8'd0) begin
                    w_state_next = S_HOLD;
                    w_cnt_next   = 8'd0;
                end else begin
                    w_cnt_next = r_cnt - 8'd1;
                end
            end
            S_HOLD: begin
                w_state_next = S_READ;
                w_cnt_next   = RD_LOAD;
            end
            S_READ: begin
                if (r_cnt == 8'd0) begin
                    w_state_next = S_RECOV;
                    w_cnt_next   = GAP_LOAD;
                end else begin
                    w_cnt_next = r_cnt - 8'd1;
                end
            end
            S_RECOV: begin
                if (r_cnt == 8'd0) begin
                    w_state_next = S_IDLE;
                    w_cnt_next   = 8'd0;
                end else begin
                    w_cnt_next = r_cnt - 8'd1;
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_cnt_next   = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= 8'd0;
            r_start_q <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_cnt     <= w_cnt_next;
            r_start_q <= start;
        end
    end

    // Pins decode the next state so they change on the same edge as the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cs_n   <= 1'b1;
            r_ad_n   <= 1'b1;
            r_rd_n   <= 1'b1;
            r_ad_oe  <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_data   <= 8'd0;
            r_addr_q <= 8'd0;
        end else begin
            if (w_trigger) begin
                r_addr_q <= addr;
            end
            if (w_capture) begin
                r_data <= ad_in;
            end
            r_cs_n  <= !((w_state_next == S_ADDR) || (w_state_next == S_HOLD) ||
                         (w_state_next == S_READ));
            r_ad_n  <= (w_state_next != S_ADDR);
            r_rd_n  <= (w_state_next != S_READ);
            r_ad_oe <= (w_state_next == S_ADDR) || (w_state_next == S_HOLD);
            r_busy  <= (w_state_next != S_IDLE);
            r_done  <= w_capture;
        end
    end

    assign ad_out = r_addr_q;
    assign ad_oe  = r_ad_oe;
    assign cs_n   = r_cs_n;
    assign ad_n   = r_ad_n;
    assign rd_n   = r_rd_n;
    assign data   = r_data;
    assign done   = r_done;
    assign busy   = r_busy;

endmodule

// File: tb/tb_bus_read_ctrl.sv
// Bench for bus_read_ctrl: three instances (default, 1/1/1, 0/1/1 timing) share
// stimulus and are compared every cycle against a cycle-count transaction model.
module tb_bus_read_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] addr;
    logic [7:0] ad_in;

    logic [7:0] ad_out [3];
    logic       ad_oe  [3];
    logic       cs_n   [3];
    logic       ad_n   [3];
    logic       rd_n   [3];
    logic [7:0] data   [3];
    logic       done   [3];
    logic       busy   [3];

    always #5 clk = ~clk;

    bus_read_ctrl u0 (
        .clk(clk), .reset(reset), .start(start), .addr(addr), .ad_in(ad_in),
        .ad_out(ad_out[0]), .ad_oe(ad_oe[0]), .cs_n(cs_n[0]), .ad_n(ad_n[0]),
        .rd_n(rd_n[0]), .data(data[0]), .done(done[0]), .busy(busy[0])
    );

    bus_read_ctrl #(.ADDR_CYC(1), .RD_CYC(1), .GAP_CYC(1)) u1 (
        .clk(clk), .reset(reset), .start(start), .addr(addr), .ad_in(ad_in),
        .ad_out(ad_out[1]), .ad_oe(ad_oe[1]), .cs_n(cs_n[1]), .ad_n(ad_n[1]),
        .rd_n(rd_n[1]), .data(data[1]), .done(done[1]), .busy(busy[1])
    );

    bus_read_ctrl #(.ADDR_CYC(0), .RD_CYC(1), .GAP_CYC(1)) u2 (
        .clk(clk), .reset(reset), .start(start), .addr(addr), .ad_in(ad_in),
        .ad_out(ad_out[2]), .ad_oe(ad_oe[2]), .cs_n(cs_n[2]), .ad_n(ad_n[2]),
        .rd_n(rd_n[2]), .data(data[2]), .done(done[2]), .busy(busy[2])
    );

    // Effective phase lengths of each instance (zero behaves as one).
    int ph_a [3] = '{4, 1, 1};
    int ph_r [3] = '{6, 1, 1};
    int ph_g [3] = '{4, 1, 1};

    // Model: a transaction is a count of cycles since the trigger edge.
    bit         m_active [3];
    int         m_cyc    [3];
    bit         m_prev   [3];
    logic [7:0] m_addr   [3];
    logic [7:0] m_data   [3];

    int checks = 0;
    int fails  = 0;
    int cycle  = 0;
    int done_cnt [3];

    task automatic model_edge();
        for (int i = 0; i < 3; i++) begin
            if (reset) begin
                m_active[i] = 1'b0;
                m_cyc[i]    = 0;
                m_prev[i]   = 1'b0;
                m_addr[i]   = 8'h00;
                m_data[i]   = 8'h00;
            end else begin
                if (m_active[i]) begin
                    if (m_cyc[i] == ph_a[i] + 1 + ph_r[i]) m_data[i] = ad_in;
                    m_cyc[i]++;
                    if (m_cyc[i] > ph_a[i] + 1 + ph_r[i] + ph_g[i]) m_active[i] = 1'b0;
                end else if (start && !m_prev[i]) begin
                    m_active[i] = 1'b1;
                    m_cyc[i]    = 1;
                    m_addr[i]   = addr;
                end
                m_prev[i] = start;
            end
        end
    endtask

    task automatic check_all();
        logic [21:0] obs, exp;
        bit in_addr, in_hold, in_read;
        int c;
        for (int i = 0; i < 3; i++) begin
            c       = m_cyc[i];
            in_addr = m_active[i] && (c >= 1) && (c <= ph_a[i]);
            in_hold = m_active[i] && (c == ph_a[i] + 1);
            in_read = m_active[i] && (c > ph_a[i] + 1) && (c <= ph_a[i] + 1 + ph_r[i]);
            exp = {m_addr[i], in_addr || in_hold, !(in_addr || in_hold || in_read),
                   !in_addr, !in_read, m_data[i],
                   m_active[i] && (c == ph_a[i] + ph_r[i] + 2), m_active[i]};
            obs = {ad_out[i], ad_oe[i], cs_n[i], ad_n[i], rd_n[i], data[i], done[i], busy[i]};
            checks++;
            assert (obs === exp) else begin
                fails++;
                $error("FAIL outputs u%0d cycle %0d: observed %h expected %h", i, cycle, obs, exp);
            end
            checks++;
            assert ((ad_oe[i] && !rd_n[i]) === 1'b0) else begin
                fails++;
                $error("FAIL oe_rd_overlap u%0d cycle %0d: observed oe=%b rd_n=%b expected not both active",
                       i, cycle, ad_oe[i], rd_n[i]);
            end
            checks++;
            assert (((!ad_n[i] || !rd_n[i]) && cs_n[i]) === 1'b0) else begin
                fails++;
                $error("FAIL cs_n_strobe u%0d cycle %0d: observed cs_n=%b ad_n=%b rd_n=%b expected cs_n=0",
                       i, cycle, cs_n[i], ad_n[i], rd_n[i]);
            end
            if (done[i] === 1'b1) done_cnt[i]++;
        end
    endtask

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            model_edge();
            cycle++;
            #1;
            check_all();
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        addr  = 8'h00;
        ad_in = 8'h00;
        tick(3);
        reset = 1'b0;
        tick(2);

        // Default-timing reference transaction.
        addr  = 8'h3A;
        ad_in = 8'hC5;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(20);
        checks++;
        assert (data[0] === 8'hC5) else begin
            fails++;
            $error("FAIL ref_data: observed %h expected c5", data[0]);
        end

        // Held start: one transaction only.
        for (int i = 0; i < 3; i++) done_cnt[i] = 0;
        addr  = 8'h5C;
        start = 1'b1;
        for (int k = 0; k < 40; k++) begin
            ad_in = 8'($urandom);
            tick(1);
        end
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            assert (done_cnt[i] === 1) else begin
                fails++;
                $error("FAIL held_start_done u%0d: observed %0d pulses expected 1", i, done_cnt[i]);
            end
        end
        tick(2);

        // Second edge inside a transaction is dropped; a later edge runs.
        addr  = 8'h11;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(6);
        addr  = 8'h22;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(12);
        addr  = 8'h33;
        start = 1'b1;
        ad_in = 8'h9E;
        tick(1);
        start = 1'b0;
        tick(18);

        // Reset during READ of the default instance.
        addr  = 8'h44;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(6);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        tick(4);

        // Start held across reset release triggers once.
        reset = 1'b1;
        start = 1'b1;
        addr  = 8'h77;
        tick(2);
        reset = 1'b0;
        tick(25);
        start = 1'b0;
        tick(2);

        // Randomized traffic.
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 3) == 0) start = ~start;
            addr  = 8'($urandom);
            ad_in = 8'($urandom);
            reset = ($urandom_range(0, 79) == 0);
            tick(1);
        end
        reset = 1'b0;
        tick(20);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
